// File: rtl/cordic_vector.sv
// +------------------------------------------------------------------------+
// | cordic_vector                                                          |
// | Iterative vectoring-mode CORDIC: (x, y) -> magnitude, atan2 in degrees |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module cordic_vector #(
  parameter int ITERS = 6,
  parameter int KINV  = 155
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] mag_out,
  output logic signed [15:0] angle_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2
  } state_t;

  localparam logic [2:0]         c_last  = 3'(ITERS - 1);
  localparam logic signed [9:0]  c_kinv  = 10'(KINV);
  localparam logic signed [17:0] c_z_180 = 18'sd46080;
  localparam logic signed [27:0] c_mag_max = 28'sd32767;

  // Elementary angles atan(2^-i), Q7.8 degrees
  localparam logic signed [17:0] c_atan [8] = '{
    18'sd11520, 18'sd6801, 18'sd3593, 18'sd1824,
    18'sd916,   18'sd458,  18'sd229,  18'sd115
  };

  state_t             r_state;
  logic signed [17:0] r_x;
  logic signed [17:0] r_y;
  logic signed [17:0] r_z;
  logic [2:0]         r_i;
  logic               r_zero;

  logic signed [17:0] w_x_ext;
  logic signed [17:0] w_y_ext;
  logic signed [17:0] w_dx;
  logic signed [17:0] w_dy;
  logic signed [27:0] w_prod;
  logic signed [27:0] w_scaled;

  assign w_x_ext  = {{2{x_in[15]}}, x_in};
  assign w_y_ext  = {{2{y_in[15]}}, y_in};
  assign w_dx     = r_x >>> r_i;
  assign w_dy     = r_y >>> r_i;
  assign w_prod   = 28'(r_x) * 28'(c_kinv);
  assign w_scaled = w_prod >>> 8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_i       <= '0;
      r_zero    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mag_out   <= '0;
      angle_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_zero  <= (x_in == 16'sd0) && (y_in == 16'sd0);
            r_i     <= '0;
            busy    <= 1'b1;
            r_state <= ST_ITER;
            // Left half-plane: rotate by 180 degrees so iterations converge
            if (x_in[15]) begin
              r_x <= -w_x_ext;
              r_y <= -w_y_ext;
              r_z <= y_in[15] ? -c_z_180 : c_z_180;
            end else begin
              r_x <= w_x_ext;
              r_y <= w_y_ext;
              r_z <= '0;
            end
          end
        end

        ST_ITER: begin
          if (!r_y[17]) begin
            r_x <= r_x + w_dy;
            r_y <= r_y - w_dx;
            r_z <= r_z + c_atan[r_i];
          end else begin
            r_x <= r_x - w_dy;
            r_y <= r_y + w_dx;
            r_z <= r_z - c_atan[r_i];
          end
          if (r_i == c_last) begin
            r_state <= ST_SCALE;
          end else begin
            r_i <= r_i + 3'd1;
          end
        end

        ST_SCALE: begin
          if (r_zero || w_scaled < 28'sd0) begin
            mag_out <= '0;
          end else if (w_scaled > c_mag_max) begin
            mag_out <= 16'sh7FFF;
          end else begin
            mag_out <= w_scaled[15:0];
          end
          angle_out <= r_zero ? 16'sd0 : r_z[16:1];
          done      <= 1'b1;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_vector.sv
// +------------------------------------------------------------------------+
// | tb_cordic_vector                                                       |
// | Self-checking bench: directed cases plus random operands vs real math  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_cordic_vector;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_in = '0;
  logic               busy;
  logic               done;
  logic signed [15:0] mag_out;
  logic signed [15:0] angle_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cordic_vector #(.ITERS(6), .KINV(155)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  // wrap=1 compares angles modulo 360 degrees (46080 in Q8.7)
  task automatic check(input string tag, input int obs, input int exp,
                       input int tol = 0, input bit wrap = 1'b0);
    int d;
    d = obs - exp;
    if (wrap) begin
      if (d > 23040) d -= 46080;
      else if (d < -23040) d += 46080;
    end
    n_cmp++;
    if (d > tol || d < -tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int ref_mag(input int x, input int y);
    real m;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    if (m > 32767.0) return 32767;
    return int'(m);
  endfunction

  function automatic int ref_ang(input int x, input int y);
    if (x == 0 && y == 0) return 0;
    return int'($atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979 * 128.0);
  endfunction

  // Called just after a rising edge; returns edges from E0 to done (-1 on timeout)
  task automatic run_op(input logic signed [15:0] xv, input logic signed [15:0] yv,
                        output int lat);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    int first_lat;
    int m0;
    int a0;
    int xr;
    int yr;
    logic signed [15:0] xv;
    logic signed [15:0] yv;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mag", mag_out, 0);
    check("rst_ang", angle_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // (1.0, 0): latency and busy profile
    x_in  = 16'sh0100;
    y_in  = 16'sh0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("t1_busy", busy, 1);
      check("t1_nodone", done, 0);
      @(posedge clk); #1;
    end
    check("t1_done", done, 1);
    check("t1_busy_low", busy, 0);
    check("t1_mag", mag_out, 16'h0100, 3);
    check("t1_ang", angle_out, 0, 128, 1'b1);
    @(posedge clk); #1;
    check("t1_pulse", done, 0);
    check("t1_hold_mag", mag_out, 16'h0100, 3);

    // 45 degrees
    run_op(16'sh0100, 16'sh0100, lat);
    check("t2_lat", lat, 7);
    check("t2_mag", mag_out, 16'h016A, 4);
    check("t2_ang", angle_out, 16'h1680, 128, 1'b1);

    // (-1, 0) -> +180 degrees
    run_op(16'shFF00, 16'sh0000, lat);
    check("t3_lat", lat, 7);
    check("t3_mag", mag_out, 16'h0100, 3);
    check("t3_ang", angle_out, 16'sh5A00, 128, 1'b1);

    // (0, -1) -> -90 degrees
    run_op(16'sh0000, 16'shFF00, lat);
    check("t3b_ang", angle_out, -11520, 128, 1'b1);
    check("t3b_mag", mag_out, 16'h0100, 3);

    // Most negative operands: magnitude saturates, -135 degrees
    run_op(16'sh8000, 16'sh8000, lat);
    check("t4_lat", lat, 7);
    check("t4_mag_sat", mag_out, 16'h7FFF);
    check("t4_ang", angle_out, -17280, 128, 1'b1);

    // Zero vector
    run_op(16'sh0000, 16'sh0000, lat);
    check("t4z_mag", mag_out, 0);
    check("t4z_ang", angle_out, 0);

    // Starts while busy are ignored
    x_in  = 16'sh0100;
    y_in  = 16'sh0100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    first_lat = -1;
    m0 = 0;
    a0 = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2 || k == 4) begin
        x_in  = -16'sd5000;
        y_in  = 16'sd1234;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first_lat < 0) begin
          first_lat = k;
          m0 = mag_out;
          a0 = angle_out;
        end
      end
    end
    check("t5_ndone", ndone, 1);
    check("t5_lat", first_lat, 7);
    check("t5_mag", m0, 16'h016A, 4);
    check("t5_ang", a0, 16'h1680, 128, 1'b1);

    // Start accepted in the done cycle
    run_op(16'sh0100, 16'sh0000, lat);
    check("t5b_done_cycle", done, 1);
    run_op(16'sh0000, 16'shFF00, lat);
    check("t5b_lat", lat, 7);
    check("t5b_ang", angle_out, -11520, 128, 1'b1);

    // Asynchronous reset mid-operation
    x_in  = 16'sh0300;
    y_in  = 16'sh0200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_mag", mag_out, 0);
    check("t6_ang", angle_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("t6_nodone", ndone, 0);
    run_op(16'sh0300, 16'sh0200, lat);
    check("t6_lat", lat, 7);
    check("t6_mag", mag_out, ref_mag(768, 512), ref_mag(768, 512) / 100 + 8);
    check("t6_ang", angle_out, ref_ang(768, 512), 300, 1'b1);

    // Random operands against real-valued atan2 / sqrt
    for (int n = 0; n < 40; n++) begin
      do begin
        xv = 16'($urandom);
        yv = 16'($urandom);
        xr = int'(xv);
        yr = int'(yv);
      end while (xr * xr + yr * yr < 1024 * 1024);
      run_op(xv, yv, lat);
      check("rnd_lat", lat, 7);
      check("rnd_mag", mag_out, ref_mag(xr, yr), ref_mag(xr, yr) / 100 + 8);
      check("rnd_ang", angle_out, ref_ang(xr, yr), 300, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cordic_vector.md
Name: cordic_vector

Overview:
- Iterative vectoring-mode CORDIC engine: the inverse of the rotation-mode SIN_COS path (rectangular to polar).
- Takes a Cartesian pair (x, y) and returns magnitude sqrt(x²+y²) and angle atan2(y, x) in degrees.
- Serves the arctan/magnitude requests of the CORDIC coprocessor; its results feed the output selection logic.

Parameters:
- ITERS, 6, number of micro-rotations (legal range 1..8).
- KINV, 155, gain compensation 1/K(ITERS) in Q0.8. 155 ≈ 0.6074 for ITERS=6. Must be recomputed if ITERS changes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only while busy=0.
- x_in  in  16  signed Q7.8 x operand.
- y_in  in  16  signed Q7.8 y operand.
- busy  out  1  high while a computation is in flight.
- done  out  1  one-cycle pulse when results update.
- mag_out  out  16  signed Q7.8 magnitude; always ≥ 0, saturating.
- angle_out  out  16  signed Q8.7 degrees, range (−180, +180].

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, mag_out=0, angle_out=0; all datapath registers cleared. Asserting rst mid-operation aborts the operation; no done is produced.
- Internal widths:
  - x, y: 18-bit signed Q9.8 (headroom for negating −128 and for gain up to ~1.65×181).
  - z: 18-bit signed Q9.8 degrees.
- FSM states: IDLE, ITER, SCALE.
- IDLE, start=1 at edge E0:
  - Sign-extend inputs.
  - If x_in<0: x=−x, y=−y, z=+180.0 when y_in≥0, else z=−180.0.
  - Otherwise z=0.
  - Set i=0, go to ITER, busy=1.
- ITER, one edge per iteration i=0..ITERS−1:
  - If y≥0: x+=y>>>i; y−=x>>>i; z+=ATAN[i].
  - Else: x−=y>>>i; y+=x>>>i; z−=ATAN[i].
  - All updates use old values; shifts are arithmetic.
  - After i=ITERS−1, go to SCALE.
- ATAN table, Q7.8 degrees, i=0..7: 11520, 6801, 3593, 1824, 916, 458, 229, 115.
- SCALE, edge E0+ITERS+1:
  - mag = (x*KINV)>>>8, saturated to 0x7FFF if >32767.
  - angle_out = z>>>1, truncated to Q8.7.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: done is visible in the cycle after edge E0+ITERS+1 (7 cycles for the default).
- Handshake:
  - start while busy=1 is ignored; the in-flight operation is unaffected.
  - start in the same cycle done=1 is accepted (FSM is already in IDLE).
  - Inputs are sampled only at E0 and may change afterwards.
- mag_out/angle_out hold their values until the next SCALE or reset.
- x=y=0 → mag_out=0, angle_out=0 (y≥0 path leaves z accumulating; the result is explicitly forced to 0 when both inputs are 0).
- Accuracy: angle error ≤ ATAN[ITERS−1]+1 LSB; magnitude error ≤ 1% +2 LSB.

Test Plan:
- Reset then x=0x0100, y=0x0000, start → done 7 cycles later; mag_out=0x0100 ±3; angle_out=0x0000 ±128 (±1°); busy high for exactly cycles 1..6.
- x=0x0100, y=0x0100 → mag_out=0x016A ±4; angle_out=0x1680 (45°) ±128.
- x=0xFF00 (−1.0), y=0 → angle_out=0x5A00 (+180°) ±128; mag_out=0x0100 ±3. Then x=0, y=0xFF00 → angle_out=0xD300 (−90°) ±128.
- x=0x8000, y=0x8000 → mag_out saturates to 0x7FFF; angle_out=0xBC80 (−135°) ±128. Then x=y=0 → both outputs 0.
- Start a job; pulse start with different operands at cycles 2 and 4 → exactly one done, with first-job results. Start again in the done cycle → second done 7 cycles later.
- Assert rst at cycle 3 of a job → busy, done and outputs go to 0 immediately (no clock edge needed); no done pulse follows. A new start after reset completes normally.
